bank_rf_wb_scheduler: RTL and testbench
=======================================

Name: bank_rf_wb_scheduler

Overview:
- Write-back scheduler in front of the 2-bank, 6-read/2-write register file (bank = addr[0]).
- Accepts up to two write-backs per cycle from the commit pipes.
- Steers each write to its bank's write port so the register file never sees a bank conflict; same-bank collisions are deferred into a small ordered queue.
- Exports a pending-register mask so issue logic can stall readers of deferred registers.

Parameters:
- WIDTH, 32, data width of one register.
- DEPTH, 4, deferred-write queue entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- wb0_valid_i  in  1  write-back 0 valid; older in program order
- wb0_addr_i  in  5  write-back 0 register address
- wb0_data_i  in  WIDTH  write-back 0 data
- wb1_valid_i  in  1  write-back 1 valid; younger
- wb1_addr_i  in  5  write-back 1 register address
- wb1_data_i  in  WIDTH  write-back 1 data
- wb_ready_o  out  1  shared ready for both write-back ports
- rf_wa0_o  out  5  regfile write port 0 address; always even bank
- rf_we0_o  out  1  regfile write port 0 enable
- rf_wd0_o  out  WIDTH  regfile write port 0 data
- rf_wa1_o  out  5  regfile write port 1 address; always odd bank
- rf_we1_o  out  1  regfile write port 1 enable
- rf_wd1_o  out  WIDTH  regfile write port 1 data
- pend_mask_o  out  32  bit r set while a queued write to register r exists
- init_busy_o  out  1  init sequence in progress (tied 0 without macro)

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous and active-low.
- Handshake:
  - Transfer on a port when valid && wb_ready_o.
  - Valid and payload must hold while ready is low.
  - wb_ready_o = (count <= DEPTH-2) && !init_busy; it depends only on registered state.
- r0 writes: accepted, never written, never enqueued.
- Queue empty, direct path (combinational, 0-cycle to regfile):
  - Banks differ: both written in the accepting cycle.
  - Same bank: wb0 written now, wb1 enqueued; same-address case keeps wb1 as the final value.
- Queue non-empty: all accepted writes are enqueued, wb0 before wb1, to preserve ordering.
- Drain each cycle:
  - Head is issued on its bank's port.
  - Head+1 is also issued if count >= 2 and its bank differs from the head's.
  - At most 2 dequeued per cycle.
- count_next = count + enq - deq. Simultaneous enqueue and drain is legal.
- Overflow is impossible by the ready rule.
- Output constraints:
  - rf_wa0_o[0] == 0 whenever rf_we0_o; rf_wa1_o[0] == 1 whenever rf_we1_o.
  - When we is low, wa and wd are don't-care but driven 0.
- pend_mask_o: OR over valid queue entries of onehot(addr), from registered state only.
- Reset: queue empty, count = 0, all outputs 0.
  - wb_ready_o rises the first cycle after rst_n = 1, or after init completes.
  - Reset mid-operation discards queued writes.

Optional Feature:
- Macro: LA_RF_INIT_EN.
- When defined:
  - FSM: INIT -> RUN. INIT is entered on reset and lasts 16 cycles, counter cnt = 0..15.
  - Each INIT cycle writes 0 to {cnt,0} on port 0 and {cnt,1} on port 1.
  - init_busy_o = 1 and wb_ready_o = 0 during INIT.
  - cnt == 15 -> RUN.
- When undefined:
  - No FSM; init_busy_o tied 0.
  - The register file is expected to self-reset or rely on its r0-only zeroing.

Decomposition:
- Package la_rf_pkg:
  - RF_ADDR_W = 5, RF_NREGS = 32, RF_BANKS = 2.
  - Function rf_bank(addr) returning addr[0].
  - FSM enum rf_init_state_e {RF_INIT, RF_RUN}.
- Sub-module la_wb_fifo:
  - Circular queue with 2-wide enqueue and 0–2 dequeue.
  - Exposes head and head+1 entries plus per-entry valid/addr for the mask.
- Top level holds the steering, drain selection and init FSM.

Test Plan:
- Different banks, empty queue: wb0 = (r4, 0xA), wb1 = (r7, 0xB) -> same cycle we0 = 1 wa0 = 4, we1 = 1 wa1 = 7; pend_mask_o stays 0.
- Same bank, same address: wb0 = (r6, 0x1), wb1 = (r6, 0x2) -> cycle 0 writes r6 = 0x1 and pend_mask_o[6] = 1 next cycle; cycle 1 writes r6 = 0x2; mask clears.
- Backpressure: DEPTH = 4, four same-bank pairs r2/r4, r8/r10, ... back-to-back -> wb_ready_o drops when count = 3; no write lost; final regfile contents match program order.
- Queue non-empty ordering: queue holds r5 = 0x10, new wb0 = (r5, 0x20) with wb1 = (r8, 0x30) -> r5 = 0x10 written before r5 = 0x20; r8 is not bypassed ahead of it.
- r0 drop and reset mid-drain: wb0 = (r0, 0xFF) -> we0 stays 0; assert rst_n = 0 with 2 queued entries -> next cycle count = 0, mask = 0, all we = 0.
- LA_RF_INIT_EN: release reset -> 16 cycles of zero writes to {0,1}..{30,31}, init_busy_o = 1 and wb_ready_o = 0; cycle 17 wb_ready_o = 1.

Source files
------------

// File: rtl/la_rf_pkg.sv
//==============================================================================
// la_rf_pkg : shared constants, bank helper and init-FSM encoding for the
//             banked register-file write-back path.
// Revision  : 1.0
//==============================================================================
`default_nettype none

package la_rf_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_NREGS  = 32;
    localparam int RF_BANKS  = 2;

    typedef enum logic [0:0] {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_init_state_e;

    function automatic logic rf_bank(input logic [RF_ADDR_W-1:0] addr);
        return addr[0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/la_wb_fifo.sv
//==============================================================================
// la_wb_fifo : ordered deferred-write queue, 0-2 enqueues and 0-2 dequeues
//              per cycle; exposes head, head+1 and per-entry valid/address.
// Revision   : 1.0
//==============================================================================
`default_nettype none

module la_wb_fifo
    import la_rf_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [1:0]                          enq_n_i,
    input  logic [RF_ADDR_W-1:0]                enq_a_addr_i,
    input  logic [WIDTH-1:0]                    enq_a_data_i,
    input  logic [RF_ADDR_W-1:0]                enq_b_addr_i,
    input  logic [WIDTH-1:0]                    enq_b_data_i,
    input  logic [1:0]                          deq_n_i,
    output logic [CW-1:0]                       count_o,
    output logic [RF_ADDR_W-1:0]                head_addr_o,
    output logic [WIDTH-1:0]                    head_data_o,
    output logic [RF_ADDR_W-1:0]                next_addr_o,
    output logic [WIDTH-1:0]                    next_data_o,
    output logic [DEPTH-1:0]                    ent_valid_o,
    output logic [DEPTH-1:0][RF_ADDR_W-1:0]     ent_addr_o
);

    logic [RF_ADDR_W-1:0] addr_q [DEPTH];
    logic [WIDTH-1:0]     data_q [DEPTH];
    logic [PW-1:0]        rd_q;
    logic [PW-1:0]        wr_q;
    logic [CW-1:0]        count_q;
    logic [PW-1:0]        w_rd1;
    logic [PW-1:0]        w_wr1;

    assign w_rd1 = rd_q + PW'(1);
    assign w_wr1 = wr_q + PW'(1);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_q + PW'(deq_n_i);
            wr_q    <= wr_q + PW'(enq_n_i);
            count_q <= count_q + CW'(enq_n_i) - CW'(deq_n_i);
        end
    end

    always_ff @(posedge clk) begin
        if (enq_n_i != 2'd0) begin
            addr_q[wr_q] <= enq_a_addr_i;
            data_q[wr_q] <= enq_a_data_i;
        end
        if (enq_n_i == 2'd2) begin
            addr_q[w_wr1] <= enq_b_addr_i;
            data_q[w_wr1] <= enq_b_data_i;
        end
    end

    assign count_o     = count_q;
    assign head_addr_o = addr_q[rd_q];
    assign head_data_o = data_q[rd_q];
    assign next_addr_o = addr_q[w_rd1];
    assign next_data_o = data_q[w_rd1];

    // An entry is live when its distance from the read pointer is below count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
        logic [PW-1:0] w_off;
        assign w_off           = PW'(gi) - rd_q;
        assign ent_valid_o[gi] = (CW'(w_off) < count_q);
        assign ent_addr_o[gi]  = addr_q[gi];
    end

endmodule

`default_nettype wire

// File: rtl/bank_rf_wb_scheduler.sv
//==============================================================================
// bank_rf_wb_scheduler : steers two write-backs per cycle onto the even/odd
//                        regfile write ports, deferring bank collisions.
// Optional macro       : LA_RF_INIT_EN (16-cycle zeroing sequence after reset)
// Revision             : 1.0
//==============================================================================
`default_nettype none

module bank_rf_wb_scheduler
    import la_rf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb0_valid_i,
    input  logic [RF_ADDR_W-1:0]  wb0_addr_i,
    input  logic [WIDTH-1:0]      wb0_data_i,
    input  logic                  wb1_valid_i,
    input  logic [RF_ADDR_W-1:0]  wb1_addr_i,
    input  logic [WIDTH-1:0]      wb1_data_i,
    output logic                  wb_ready_o,
    output logic [RF_ADDR_W-1:0]  rf_wa0_o,
    output logic                  rf_we0_o,
    output logic [WIDTH-1:0]      rf_wd0_o,
    output logic [RF_ADDR_W-1:0]  rf_wa1_o,
    output logic                  rf_we1_o,
    output logic [WIDTH-1:0]      rf_wd1_o,
    output logic [RF_NREGS-1:0]   pend_mask_o,
    output logic                  init_busy_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic                              run_q;
    logic                              w_init_busy;
    logic [3:0]                        w_init_cnt;
    logic                              w_ready;
    logic                              w_acc0;
    logic                              w_acc1;
    logic                              w_empty;
    logic [CW-1:0]                     w_count;
    logic [RF_ADDR_W-1:0]              w_head_addr;
    logic [WIDTH-1:0]                  w_head_data;
    logic [RF_ADDR_W-1:0]              w_next_addr;
    logic [WIDTH-1:0]                  w_next_data;
    logic [DEPTH-1:0]                  w_ent_valid;
    logic [DEPTH-1:0][RF_ADDR_W-1:0]   w_ent_addr;
    logic [1:0]                        w_enq_n;
    logic [1:0]                        w_deq_n;
    logic [RF_ADDR_W-1:0]              w_enq_a_addr;
    logic [WIDTH-1:0]                  w_enq_a_data;
    logic [RF_ADDR_W-1:0]              w_enq_b_addr;
    logic [WIDTH-1:0]                  w_enq_b_data;
    logic                              w_we [RF_BANKS];
    logic [RF_ADDR_W-1:0]              w_wa [RF_BANKS];
    logic [WIDTH-1:0]                  w_wd [RF_BANKS];
    logic [RF_NREGS-1:0]               w_pend;

    // Holds ready low during reset and for the cycle in which it is released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

`ifdef LA_RF_INIT_EN
    rf_init_state_e state_q;
    rf_init_state_e state_d;
    logic [3:0]     cnt_q;
    logic [3:0]     cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RF_INIT;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if ((state_q == RF_INIT) && run_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                state_d = RF_RUN;
            end
        end
    end

    assign w_init_busy = run_q && (state_q == RF_INIT);
    assign w_init_cnt  = cnt_q;
`else
    assign w_init_busy = 1'b0;
    assign w_init_cnt  = 4'd0;
`endif

    assign w_ready = run_q && !w_init_busy && (w_count <= CW'(DEPTH - 2));
    assign w_acc0  = wb0_valid_i && w_ready && (wb0_addr_i != '0);
    assign w_acc1  = wb1_valid_i && w_ready && (wb1_addr_i != '0);
    assign w_empty = (w_count == '0);

    la_wb_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .enq_n_i      (w_enq_n),
        .enq_a_addr_i (w_enq_a_addr),
        .enq_a_data_i (w_enq_a_data),
        .enq_b_addr_i (w_enq_b_addr),
        .enq_b_data_i (w_enq_b_data),
        .deq_n_i      (w_deq_n),
        .count_o      (w_count),
        .head_addr_o  (w_head_addr),
        .head_data_o  (w_head_data),
        .next_addr_o  (w_next_addr),
        .next_data_o  (w_next_data),
        .ent_valid_o  (w_ent_valid),
        .ent_addr_o   (w_ent_addr)
    );

    always_comb begin
        for (int b = 0; b < RF_BANKS; b++) begin
            w_we[b] = 1'b0;
            w_wa[b] = '0;
            w_wd[b] = '0;
        end
        w_enq_n      = 2'd0;
        w_deq_n      = 2'd0;
        w_enq_a_addr = '0;
        w_enq_a_data = '0;
        w_enq_b_addr = '0;
        w_enq_b_data = '0;

        if (w_init_busy) begin
            w_we[0] = 1'b1;
            w_wa[0] = {w_init_cnt, 1'b0};
            w_we[1] = 1'b1;
            w_wa[1] = {w_init_cnt, 1'b1};
        end else if (w_empty) begin
            if (w_acc0) begin
                w_we[rf_bank(wb0_addr_i)] = 1'b1;
                w_wa[rf_bank(wb0_addr_i)] = wb0_addr_i;
                w_wd[rf_bank(wb0_addr_i)] = wb0_data_i;
            end
            if (w_acc1) begin
                // Bank collision: wb0 takes the port, wb1 waits so it still lands last.
                if (w_acc0 && (rf_bank(wb0_addr_i) == rf_bank(wb1_addr_i))) begin
                    w_enq_n      = 2'd1;
                    w_enq_a_addr = wb1_addr_i;
                    w_enq_a_data = wb1_data_i;
                end else begin
                    w_we[rf_bank(wb1_addr_i)] = 1'b1;
                    w_wa[rf_bank(wb1_addr_i)] = wb1_addr_i;
                    w_wd[rf_bank(wb1_addr_i)] = wb1_data_i;
                end
            end
        end else begin
            w_we[rf_bank(w_head_addr)] = 1'b1;
            w_wa[rf_bank(w_head_addr)] = w_head_addr;
            w_wd[rf_bank(w_head_addr)] = w_head_data;
            w_deq_n = 2'd1;
            if ((w_count >= CW'(2)) && (rf_bank(w_next_addr) != rf_bank(w_head_addr))) begin
                w_we[rf_bank(w_next_addr)] = 1'b1;
                w_wa[rf_bank(w_next_addr)] = w_next_addr;
                w_wd[rf_bank(w_next_addr)] = w_next_data;
                w_deq_n = 2'd2;
            end
            // New writes queue behind existing entries to keep program order.
            if (w_acc0 && w_acc1) begin
                w_enq_n      = 2'd2;
                w_enq_a_addr = wb0_addr_i;
                w_enq_a_data = wb0_data_i;
                w_enq_b_addr = wb1_addr_i;
                w_enq_b_data = wb1_data_i;
            end else if (w_acc0) begin
                w_enq_n      = 2'd1;
                w_enq_a_addr = wb0_addr_i;
                w_enq_a_data = wb0_data_i;
            end else if (w_acc1) begin
                w_enq_n      = 2'd1;
                w_enq_a_addr = wb1_addr_i;
                w_enq_a_data = wb1_data_i;
            end
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_valid[i]) begin
                w_pend[w_ent_addr[i]] = 1'b1;
            end
        end
    end

    assign wb_ready_o  = w_ready;
    assign rf_we0_o    = w_we[0];
    assign rf_wa0_o    = w_wa[0];
    assign rf_wd0_o    = w_wd[0];
    assign rf_we1_o    = w_we[1];
    assign rf_wa1_o    = w_wa[1];
    assign rf_wd1_o    = w_wd[1];
    assign pend_mask_o = w_pend;
    assign init_busy_o = w_init_busy;

endmodule

`default_nettype wire

// File: tb/tb_bank_rf_wb_scheduler.sv
//==============================================================================
// tb_bank_rf_wb_scheduler : directed + random stimulus against a queue-based
//                           reference model and program-order regfile image.
// Revision                : 1.0
//==============================================================================
`default_nettype none

module tb_bank_rf_wb_scheduler;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]       addr;
        logic [WIDTH-1:0] data;
    } wb_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wb0_valid_i = 1'b0;
    logic [4:0]       wb0_addr_i = '0;
    logic [WIDTH-1:0] wb0_data_i = '0;
    logic             wb1_valid_i = 1'b0;
    logic [4:0]       wb1_addr_i = '0;
    logic [WIDTH-1:0] wb1_data_i = '0;
    logic             wb_ready_o;
    logic [4:0]       rf_wa0_o;
    logic             rf_we0_o;
    logic [WIDTH-1:0] rf_wd0_o;
    logic [4:0]       rf_wa1_o;
    logic             rf_we1_o;
    logic [WIDTH-1:0] rf_wd1_o;
    logic [31:0]      pend_mask_o;
    logic             init_busy_o;

    always #5 clk = ~clk;

    bank_rf_wb_scheduler #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb0_valid_i (wb0_valid_i),
        .wb0_addr_i  (wb0_addr_i),
        .wb0_data_i  (wb0_data_i),
        .wb1_valid_i (wb1_valid_i),
        .wb1_addr_i  (wb1_addr_i),
        .wb1_data_i  (wb1_data_i),
        .wb_ready_o  (wb_ready_o),
        .rf_wa0_o    (rf_wa0_o),
        .rf_we0_o    (rf_we0_o),
        .rf_wd0_o    (rf_wd0_o),
        .rf_wa1_o    (rf_wa1_o),
        .rf_we1_o    (rf_we1_o),
        .rf_wd1_o    (rf_wd1_o),
        .pend_mask_o (pend_mask_o),
        .init_busy_o (init_busy_o)
    );

    int               n_vec = 0;
    int               n_err = 0;
    wb_t              mq[$];
    logic             m_run = 1'b0;
    logic [WIDTH-1:0] ref_rf [32];
    logic [WIDTH-1:0] obs_rf [32];
    logic             e_we [2];
    logic [4:0]       e_wa [2];
    logic [WIDTH-1:0] e_wd [2];
    logic [4:0]       bp0 [4] = '{5'd2, 5'd8,  5'd12, 5'd16};
    logic [4:0]       bp1 [4] = '{5'd4, 5'd10, 5'd14, 5'd18};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [4:0] a, input logic [WIDTH-1:0] d);
        e_we[a[0]] = 1'b1;
        e_wa[a[0]] = a;
        e_wd[a[0]] = d;
    endtask

    task automatic clear_rf();
        for (int i = 0; i < 32; i++) begin
            ref_rf[i] = '0;
            obs_rf[i] = '0;
        end
    endtask

    // One cycle: drive inputs, predict every output from the queue model, check, advance model.
    task automatic step(input logic r,
                        input logic v0, input logic [4:0] a0, input logic [WIDTH-1:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [WIDTH-1:0] d1,
                        output logic acc);
        logic        erdy;
        logic        t0;
        logic        t1;
        logic        push1;
        logic [31:0] emask;
        int          n;
        @(negedge clk);
        rst_n       = r;
        wb0_valid_i = v0; wb0_addr_i = a0; wb0_data_i = d0;
        wb1_valid_i = v1; wb1_addr_i = a1; wb1_data_i = d1;
        #2;
        erdy  = m_run && (mq.size() <= DEPTH - 2);
        t0    = erdy && v0 && (a0 != 5'd0);
        t1    = erdy && v1 && (a1 != 5'd0);
        push1 = 1'b0;
        n     = 0;
        emask = '0;
        foreach (mq[i]) emask[mq[i].addr] = 1'b1;
        for (int b = 0; b < 2; b++) begin
            e_we[b] = 1'b0; e_wa[b] = '0; e_wd[b] = '0;
        end
        if (mq.size() == 0) begin
            if (t0) put(a0, d0);
            if (t1) begin
                if (t0 && (a0[0] == a1[0])) push1 = 1'b1;
                else put(a1, d1);
            end
        end else begin
            put(mq[0].addr, mq[0].data);
            n = 1;
            if (mq.size() >= 2 && (mq[1].addr[0] != mq[0].addr[0])) begin
                put(mq[1].addr, mq[1].data);
                n = 2;
            end
        end
        chk("wb_ready", wb_ready_o, erdy);
        chk("we0", rf_we0_o, e_we[0]);
        chk("wa0", rf_wa0_o, e_wa[0]);
        chk("wd0", rf_wd0_o, e_wd[0]);
        chk("we1", rf_we1_o, e_we[1]);
        chk("wa1", rf_wa1_o, e_wa[1]);
        chk("wd1", rf_wd1_o, e_wd[1]);
        chk("pend_mask", pend_mask_o, emask);
        chk("init_busy", init_busy_o, 1'b0);
        if (!r) begin
            mq.delete();
            clear_rf();
            m_run = 1'b0;
        end else begin
            if (rf_we0_o) obs_rf[rf_wa0_o] = rf_wd0_o;
            if (rf_we1_o) obs_rf[rf_wa1_o] = rf_wd1_o;
            if (mq.size() != 0) begin
                repeat (n) void'(mq.pop_front());
                if (t0) mq.push_back('{a0, d0});
                if (t1) mq.push_back('{a1, d1});
            end else if (push1) begin
                mq.push_back('{a1, d1});
            end
            if (t0) ref_rf[a0] = d0;
            if (t1) ref_rf[a1] = d1;
            m_run = 1'b1;
        end
        acc = erdy;
    endtask

    task automatic idle(input logic r);
        logic acc;
        step(r, 1'b0, '0, '0, 1'b0, '0, '0, acc);
    endtask

    // Holds the offer until accepted, as the handshake requires.
    task automatic offer(input logic v0, input logic [4:0] a0, input logic [WIDTH-1:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [WIDTH-1:0] d1);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 16) begin
            step(1'b1, v0, a0, d0, v1, a1, d1, acc);
            tries++;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL offer_timeout: observed no acceptance, expected acceptance within 16 cycles");
        end
    endtask

    initial begin
        logic             rv0, rv1, held, acc;
        logic [4:0]       ra0, ra1;
        logic [WIDTH-1:0] rd0, rd1;
        int               guard;

        clear_rf();
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);

        offer(1'b1, 5'd4, 32'hA, 1'b1, 5'd7, 32'hB);
        idle(1'b1);

        offer(1'b1, 5'd6, 32'h1, 1'b1, 5'd6, 32'h2);
        repeat (3) idle(1'b1);

        for (int k = 0; k < 4; k++) begin
            offer(1'b1, bp0[k], 32'h100 + k, 1'b1, bp1[k], 32'h200 + k);
        end
        repeat (8) idle(1'b1);

        offer(1'b1, 5'd3, 32'h1, 1'b1, 5'd5, 32'h10);
        offer(1'b1, 5'd5, 32'h20, 1'b1, 5'd8, 32'h30);
        repeat (5) idle(1'b1);

        offer(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0);
        idle(1'b1);

        offer(1'b1, 5'd2, 32'h55, 1'b1, 5'd4, 32'h66);
        offer(1'b1, 5'd6, 32'h77, 1'b1, 5'd8, 32'h88);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        held = 1'b0;
        rv0 = 1'b0; rv1 = 1'b0; ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
        for (int c = 0; c < 400; c++) begin
            if (!held) begin
                rv0 = ($urandom_range(0, 3) != 0);
                rv1 = ($urandom_range(0, 3) != 0);
                ra0 = 5'($urandom_range(0, 31));
                ra1 = 5'($urandom_range(0, 31));
                rd0 = $urandom;
                rd1 = $urandom;
            end
            step(1'b1, rv0, ra0, rd0, rv1, ra1, rd1, acc);
            held = !acc && (rv0 || rv1);
        end

        guard = 0;
        while (mq.size() != 0 && guard < 20) begin
            idle(1'b1);
            guard++;
        end
        idle(1'b1);
        for (int r = 1; r < 32; r++) begin
            chk($sformatf("regfile_r%0d", r), obs_rf[r], ref_rf[r]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
